// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle 8-bit lab CPU: widths, opcodes and ALU selects.
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam int PC_W       = 32;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_sel_e;

endpackage

// File: rtl/cpu_reg_file.sv
// 8 x 8-bit register file: two combinational read ports, one synchronous write port.
module reg_file
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle 8-bit CPU core: fetch at PC, decode, read, ALU and write back in one clock.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 32'd0
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic [PC_W-1:0] PC,
    input  logic [31:0]     INSTRUCTION
);

    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       pc_d;
    logic [7:0]            opcode;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [DATA_W-1:0]     operand2;
    logic [DATA_W-1:0]     alu_b;
    logic [DATA_W-1:0]     alu_result;
    logic                  reg_we;
    logic                  use_imm;
    logic                  negate;
    alu_sel_e              alu_sel;
    logic                  unused_addr_bits;

    assign opcode   = INSTRUCTION[31:24];
    assign rd_addr  = INSTRUCTION[16 +: REG_ADDR_W];
    assign rs1_addr = INSTRUCTION[8 +: REG_ADDR_W];
    assign rs2_addr = INSTRUCTION[0 +: REG_ADDR_W];
    assign imm      = INSTRUCTION[7:0];

    // Only the low three bits of each register-address byte are decoded.
    assign unused_addr_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    always_comb begin
        reg_we  = 1'b0;
        use_imm = 1'b0;
        negate  = 1'b0;
        alu_sel = ALU_FWD;
        case (opcode)
            OP_LOADI: begin reg_we = 1'b1; use_imm = 1'b1; end
            OP_MOV:   begin reg_we = 1'b1; end
            OP_ADD:   begin reg_we = 1'b1; alu_sel = ALU_ADD; end
            OP_SUB:   begin reg_we = 1'b1; alu_sel = ALU_ADD; negate = 1'b1; end
            OP_AND:   begin reg_we = 1'b1; alu_sel = ALU_AND; end
            OP_OR:    begin reg_we = 1'b1; alu_sel = ALU_OR; end
            default:  begin reg_we = 1'b0; end
        endcase
    end

    assign operand2 = use_imm ? imm : rdata2;
    assign alu_b    = negate ? (~operand2 + 8'd1) : operand2;

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            ALU_FWD: alu_result = alu_b;
            ALU_ADD: alu_result = rdata1 + alu_b;
            ALU_AND: alu_result = rdata1 & alu_b;
            ALU_OR:  alu_result = rdata1 | alu_b;
            default: alu_result = '0;
        endcase
    end

    reg_file u_reg_file (
        .clk    (CLK),
        .rst    (RESET),
        .we     (reg_we),
        .waddr  (rd_addr),
        .wdata  (alu_result),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always_comb begin
        pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed program, instruction-level reference model, per-cycle compare.
module tb_cpu;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;

    logic [31:0] imem [0:31];
    logic [7:0]  m_regs [0:7];
    logic [31:0] m_pc;
    int          checks;
    int          passes;
    bit          compare_on;

    cpu #(.PC_RESET(32'd0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION)
    );

    initial CLK = 1'b0;
    always #4 CLK = ~CLK;

    function automatic logic [31:0] fetch(input logic [31:0] addr);
        if (addr < 32'd128) return imem[addr[6:2]];
        return 32'hFF00_0000;
    endfunction

    always_comb INSTRUCTION = fetch(PC);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] peek(input int i);
        return dut.u_reg_file.regs[i];
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endtask

    // Architectural reference: one whole instruction per rising edge.
    task automatic model_step();
        logic [31:0] w;
        logic [7:0]  a, b;
        int          d;
        w = fetch(m_pc);
        d = int'(w[18:16]);
        a = m_regs[w[10:8]];
        b = m_regs[w[2:0]];
        case (w[31:24])
            8'h00: m_regs[d] = w[7:0];
            8'h01: m_regs[d] = b;
            8'h02: m_regs[d] = 8'((int'(a) + int'(b)) % 256);
            8'h03: m_regs[d] = 8'((int'(a) - int'(b) + 256) % 256);
            8'h04: m_regs[d] = a & b;
            8'h05: m_regs[d] = a | b;
            default: ;
        endcase
        m_pc = m_pc + 32'd4;
    endtask

    always @(posedge RESET) model_reset();

    always @(posedge CLK) begin
        if (RESET) model_reset();
        else model_step();
    end

    always @(negedge CLK) begin
        if (compare_on) begin
            check("pc_vs_model", PC, m_pc);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("r%0d_vs_model", i), {24'd0, peek(i)}, {24'd0, m_regs[i]});
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pin(input string name, input int r, input logic [7:0] exp);
        check({"dut_", name}, {24'd0, peek(r)}, {24'd0, exp});
        check({"model_", name}, {24'd0, m_regs[r]}, {24'd0, exp});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passes = 0;
        compare_on = 1'b0;
        for (int i = 0; i < 32; i++) imem[i] = 32'hFF00_0000;
        imem[0]  = 32'h0004_0005; // loadi r4,5
        imem[1]  = 32'h0002_0009; // loadi r2,9
        imem[2]  = 32'h0206_0402; // add r6,r4,r2
        imem[3]  = 32'h0301_0204; // sub r1,r2,r4
        imem[4]  = 32'h0301_0402; // sub r1,r4,r2
        imem[5]  = 32'h0403_0402; // and r3,r4,r2
        imem[6]  = 32'h0503_0402; // or  r3,r4,r2
        imem[7]  = 32'h0107_0006; // mov r7,r6
        imem[8]  = 32'h0000_00FF; // loadi r0,FF
        imem[9]  = 32'h0001_0002; // loadi r1,02
        imem[10] = 32'h0205_0001; // add r5,r0,r1
        imem[11] = 32'h000D_0077; // loadi with DEST byte 0D -> r5
        imem[12] = 32'hFFFF_FFFF; // undefined opcode
        imem[13] = 32'h0607_0102; // undefined opcode
        model_reset();

        RESET = 1'b1;
        #2;
        check("pc_in_reset", PC, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("r%0d_in_reset", i), {24'd0, peek(i)}, 32'd0);
        #3 RESET = 1'b0;
        compare_on = 1'b1;

        run(1); check("pc_after_1", PC, 32'd4);
        run(1); check("pc_after_2", PC, 32'd8);
        run(1); check("pc_after_3", PC, 32'd12);
        pin("loadi_r4", 4, 8'd5);
        pin("loadi_r2", 2, 8'd9);
        pin("add_r6", 6, 8'd14);
        run(1); pin("sub_r1_pos", 1, 8'd4);
        run(1); pin("sub_r1_neg", 1, 8'hFC);
        run(1); pin("and_r3", 3, 8'd1);
        run(1); pin("or_r3", 3, 8'd13);
        run(1); pin("mov_r7", 7, 8'd14);
        run(3);
        pin("loadi_r0", 0, 8'hFF);
        pin("loadi_r1", 1, 8'h02);
        pin("add_wrap_r5", 5, 8'h01);
        run(1); pin("dest_low_bits_r5", 5, 8'h77);
        run(2);
        pin("nop_keeps_r7", 7, 8'd14);
        pin("nop_keeps_r1", 1, 8'h02);
        check("pc_after_nops", PC, 32'd56);

        // Restart from scratch: let the last few instructions run, then reset between edges.
        #2 RESET = 1'b1;
        #1;
        check("pc_mid_reset", PC, 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("r%0d_mid_reset", i), {24'd0, peek(i)}, 32'd0);
        #1 RESET = 1'b0;
        run(3);
        check("pc_rerun_3", PC, 32'd12);
        pin("rerun_r4", 4, 8'd5);
        pin("rerun_r2", 2, 8'd9);
        pin("rerun_r6", 6, 8'd14);
        run(9);
        pin("rerun_r5", 5, 8'h77);
        pin("rerun_r3", 3, 8'd13);
        pin("rerun_r0", 0, 8'hFF);
        run(2);
        compare_on = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
